// File: rtl/mcp_mem_port.sv
// mcp_mem_port: load/store sequencer on the initiator side of the single-port data memory.
// Accepts one byte/halfword/word request at a time, extends sub-word loads and performs
// read-modify-write for sub-word stores. Memory read data is asynchronous to MRA.
module mcp_mem_port #(
  parameter int unsigned WL = 32,
  parameter int unsigned AL = 9
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ,
  input  logic          WE,
  input  logic [1:0]    SIZE,
  input  logic          UNS,
  input  logic [31:0]   ADDR,
  input  logic [WL-1:0] WDATA,
  output logic [WL-1:0] RDATA,
  output logic          DONE,
  output logic          ERR,
  output logic          BUSY,
  output logic          MWE,
  output logic [AL-1:0] MRA,
  output logic [WL-1:0] MWD,
  input  logic [WL-1:0] MRD
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StFin} state_e;

  state_e        r_state;
  state_e        w_state_next;

  logic          r_we;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [1:0]    r_off;
  logic [WL-1:0] r_wdata;
  logic          r_err;
  logic [WL-1:0] r_rdata;
  logic [AL-1:0] r_mra;
  logic [WL-1:0] r_mwd;

  logic          w_req_err;
  logic [7:0]    w_lane_b;
  logic [15:0]   w_lane_h;
  logic [WL-1:0] w_load;
  logic [WL-1:0] w_merge;

  // Address bits above the word index are dropped: the memory wraps modulo 2^AL words.
  logic          unused_addr;
  assign unused_addr = ^ADDR[31:AL+2];

  // Misaligned or illegal-size requests are rejected at accept time.
  assign w_req_err = (SIZE == 2'b11) ||
                     ((SIZE == 2'b01) && ADDR[0]) ||
                     ((SIZE == 2'b10) && (ADDR[1:0] != 2'b00));

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; REQ only matters in idle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (REQ) begin
          if (w_req_err) begin
            w_state_next = StFin;
          end else if (WE && (SIZE == 2'b10)) begin
            w_state_next = StWrite;
          end else begin
            w_state_next = StRead;
          end
        end
      end
      StRead:  w_state_next = r_we ? StWrite : StFin;
      StWrite: w_state_next = StFin;
      StFin:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs decoded from state; MWE is gated by RST so an aborted store never commits.
  always_comb begin
    BUSY = (r_state != StIdle);
    DONE = (r_state == StFin);
    ERR  = (r_state == StFin) && r_err;
    MWE  = (r_state == StWrite) && !RST;
  end

  // Lane selection for loads and lane replacement for sub-word stores (little-endian).
  always_comb begin
    w_lane_b = MRD[{r_off, 3'b000} +: 8];
    w_lane_h = r_off[1] ? MRD[31:16] : MRD[15:0];
    w_load   = MRD;
    w_merge  = MRD;
    case (r_size)
      2'b00: begin
        w_load = {{(WL-8){w_lane_b[7] & ~r_uns}}, w_lane_b};
        w_merge[{r_off, 3'b000} +: 8] = r_wdata[7:0];
      end
      2'b01: begin
        w_load = {{(WL-16){w_lane_h[15] & ~r_uns}}, w_lane_h};
        w_merge[{r_off[1], 4'b0000} +: 16] = r_wdata[15:0];
      end
      default: begin
        w_load  = MRD;
        w_merge = MRD;
      end
    endcase
  end

  // Request latch and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_off   <= 2'b00;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_mra   <= '0;
      r_mwd   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (REQ) begin
            r_we    <= WE;
            r_size  <= SIZE;
            r_uns   <= UNS;
            r_off   <= ADDR[1:0];
            r_wdata <= WDATA;
            r_err   <= w_req_err;
            r_mra   <= ADDR[AL+1:2];
            // Word stores skip the read, so the write data is staged here.
            if (!w_req_err && WE && (SIZE == 2'b10)) begin
              r_mwd <= WDATA;
            end
          end
        end
        StRead: begin
          if (r_we) begin
            r_mwd <= w_merge;
          end else begin
            r_rdata <= w_load;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign RDATA = r_rdata;
  assign MRA   = r_mra;
  assign MWD   = r_mwd;

endmodule

// File: tb/tb_mcp_mem_port.sv
// Bench for mcp_mem_port: directed requests, a transaction-level model that predicts each
// cycle's outputs, and a per-cycle compare process; literal checks pin the model.
module tb_mcp_mem_port;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ = 1'b0;
  logic        WE = 1'b0;
  logic [1:0]  SIZE = 2'b00;
  logic        UNS = 1'b0;
  logic [31:0] ADDR = '0;
  logic [31:0] WDATA = '0;
  logic [31:0] RDATA;
  logic        DONE;
  logic        ERR;
  logic        BUSY;
  logic        MWE;
  logic [8:0]  MRA;
  logic [31:0] MWD;
  logic [31:0] MRD;

  mcp_mem_port #(.WL(32), .AL(9)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .SIZE(SIZE), .UNS(UNS), .ADDR(ADDR),
    .WDATA(WDATA), .RDATA(RDATA), .DONE(DONE), .ERR(ERR), .BUSY(BUSY), .MWE(MWE),
    .MRA(MRA), .MWD(MWD), .MRD(MRD)
  );

  always #5 CLK = ~CLK;

  // Single-port memory with asynchronous read.
  logic [31:0] mem [512];
  assign MRD = mem[MRA];
  always @(posedge CLK) if (MWE) mem[MRA] <= MWD;

  // Model state: reference memory contents and the architectural RDATA.
  logic [31:0] ref_mem [512];
  logic [31:0] m_rdata = '0;

  typedef struct {
    logic        busy;
    logic        done;
    logic        err;
    logic        mwe;
    logic [31:0] rdata;
    bit          chk_mra;
    logic [8:0]  mra;
    bit          chk_mwd;
    logic [31:0] mwd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t idle_rec();
    exp_t r;
    r.busy = 0; r.done = 0; r.err = 0; r.mwe = 0; r.rdata = m_rdata;
    r.chk_mra = 0; r.mra = '0; r.chk_mwd = 0; r.mwd = '0;
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] size,
                                         input logic uns, input logic [1:0] off);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (w >> (int'(off) * 8)) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      v = (w >> (int'(off[1]) * 16)) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] size, input logic [1:0] off);
    int sh;
    logic [31:0] mask;
    sh   = (size == 2'd0) ? int'(off) * 8 : int'(off[1]) * 16;
    mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  // One compare per cycle, on the falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (cmp_en) begin
        exp_t e;
        if (q.size() > 0) e = q.pop_front();
        else e = idle_rec();
        check("busy", {31'd0, BUSY}, {31'd0, e.busy});
        check("done", {31'd0, DONE}, {31'd0, e.done});
        check("mwe", {31'd0, MWE}, {31'd0, e.mwe});
        check("rdata", RDATA, e.rdata);
        if (e.done) check("err", {31'd0, ERR}, {31'd0, e.err});
        if (e.chk_mra) check("mra", {23'd0, MRA}, {23'd0, e.mra});
        if (e.chk_mwd) check("mwd", MWD, e.mwd);
      end
    end
  end

  // Issue one request at the start of a cycle, predict its timeline, and return at the
  // start of the first idle cycle after FIN. REQ is held high with junk while busy.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        r;
    int          idx;
    int          n;
    logic        err;
    logic [31:0] nw;
    idx = int'(addr[10:2]);
    err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    q.push_back(idle_rec());
    r = idle_rec();
    r.busy = 1;
    if (err) begin
      r.done = 1; r.err = 1; q.push_back(r);
      n = 1;
    end else if (!we) begin
      nw = m_load(ref_mem[idx], size, uns, addr[1:0]);
      r.chk_mra = 1; r.mra = addr[10:2]; q.push_back(r);
      r.chk_mra = 0; r.done = 1; r.rdata = nw; q.push_back(r);
      m_rdata = nw;
      n = 2;
    end else if (size == 2'd2) begin
      r.mwe = 1; r.chk_mra = 1; r.mra = addr[10:2]; r.chk_mwd = 1; r.mwd = wdata;
      q.push_back(r);
      r = idle_rec(); r.busy = 1; r.done = 1; q.push_back(r);
      ref_mem[idx] = wdata;
      n = 2;
    end else begin
      nw = m_store(ref_mem[idx], wdata, size, addr[1:0]);
      r.chk_mra = 1; r.mra = addr[10:2]; q.push_back(r);
      r.mwe = 1; r.chk_mwd = 1; r.mwd = nw; q.push_back(r);
      r = idle_rec(); r.busy = 1; r.done = 1; q.push_back(r);
      ref_mem[idx] = nw;
      n = 3;
    end
    REQ = 1; WE = we; SIZE = size; UNS = uns; ADDR = addr; WDATA = wdata;
    @(posedge CLK); #1;
    WE = ~we; SIZE = 2'd0; UNS = ~uns; ADDR = 32'hFFFF_FFFF; WDATA = 32'h5555_5555;
    repeat (n) begin
      @(posedge CLK); #1;
    end
    REQ = 0;
  endtask

  // Byte store aborted by RST during its WRITE cycle.
  task automatic reset_during_write(input logic [31:0] addr, input logic [31:0] wdata);
    exp_t r;
    int   idx;
    idx = int'(addr[10:2]);
    q.push_back(idle_rec());
    r = idle_rec(); r.busy = 1; r.chk_mra = 1; r.mra = addr[10:2]; q.push_back(r);
    r.chk_mwd = 1; r.mwd = m_store(ref_mem[idx], wdata, 2'd0, addr[1:0]); q.push_back(r);
    REQ = 1; WE = 1; SIZE = 2'd0; UNS = 0; ADDR = addr; WDATA = wdata;
    @(posedge CLK); #1;
    REQ = 0;
    @(posedge CLK); #1;
    RST = 1;
    @(posedge CLK); #1;
    RST = 0;
    m_rdata = '0;
    check("rst_rdata", RDATA, 32'h0);
    check("rst_mra", {23'd0, MRA}, 32'h0);
    check("rst_mwd", MWD, 32'h0);
    check("rst_busy", {31'd0, BUSY}, 32'h0);
    check("rst_done", {31'd0, DONE}, 32'h0);
    check("rst_mem4", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    mem[4] = 32'h80FF7F01;
    ref_mem[4] = 32'h80FF7F01;

    repeat (2) @(posedge CLK);
    #1;
    check("reset_busy", {31'd0, BUSY}, 32'h0);
    check("reset_done", {31'd0, DONE}, 32'h0);
    check("reset_err", {31'd0, ERR}, 32'h0);
    check("reset_mwe", {31'd0, MWE}, 32'h0);
    check("reset_rdata", RDATA, 32'h0);
    check("reset_mra", {23'd0, MRA}, 32'h0);
    check("reset_mwd", MWD, 32'h0);
    RST = 0;
    cmp_en = 1;

    do_req(0, 2'd0, 0, 32'h13, 32'h0);  check("lb", RDATA, 32'hFFFFFF80);
    do_req(0, 2'd0, 1, 32'h13, 32'h0);  check("lbu", RDATA, 32'h00000080);
    do_req(0, 2'd1, 0, 32'h12, 32'h0);  check("lh", RDATA, 32'hFFFF80FF);
    do_req(0, 2'd1, 1, 32'h10, 32'h0);  check("lhu", RDATA, 32'h00007F01);
    do_req(0, 2'd2, 0, 32'h10, 32'h0);  check("lw", RDATA, 32'h80FF7F01);

    do_req(1, 2'd0, 0, 32'h11, 32'h000000AB);
    check("sb_mem", mem[4], 32'h80FFAB01);
    check("sb_rdata", RDATA, 32'h80FF7F01);
    do_req(0, 2'd2, 0, 32'h10, 32'h0);  check("lw_after_sb", RDATA, 32'h80FFAB01);

    do_req(1, 2'd2, 0, 32'h14, 32'hDEADBEEF);
    check("sw_mem", mem[5], 32'hDEADBEEF);
    do_req(0, 2'd2, 0, 32'h14, 32'h0);  check("lw5", RDATA, 32'hDEADBEEF);

    do_req(0, 2'd2, 0, 32'h12, 32'h0);
    do_req(1, 2'd1, 0, 32'h11, 32'h0000FFFF);
    do_req(0, 2'd3, 0, 32'h10, 32'h0);
    do_req(1, 2'd3, 0, 32'h10, 32'h0);
    check("err_rdata", RDATA, 32'hDEADBEEF);
    check("err_mem4", mem[4], 32'h80FFAB01);
    check("err_mem5", mem[5], 32'hDEADBEEF);

    do_req(1, 2'd1, 0, 32'h16, 32'h00001234);
    do_req(0, 2'd2, 0, 32'h14, 32'h0);  check("lw_after_sh", RDATA, 32'h1234BEEF);
    do_req(0, 2'd0, 0, 32'h17, 32'h0);  check("lb_hi", RDATA, 32'h00000012);
    do_req(0, 2'd2, 0, 32'h810, 32'h0); check("lw_wrap", RDATA, 32'h80FFAB01);

    reset_during_write(32'h10, 32'h0000005A);
    do_req(0, 2'd2, 0, 32'h10, 32'h0);  check("lw_after_rst", RDATA, 32'h80FFAB01);

    repeat (2) @(posedge CLK);
    #1;
    for (int i = 0; i < 8; i++) check("mem_final", mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
